lmsm_sequencer: RTL and testbench

- Expands each load-multiple (`lm`) or store-multiple (`sm`) instruction held in the ID stage into a sequence of single-register micro-ops.
- Issues one micro-op per cycle into ID/RR, lowest register first.
- Holds fetch and decode until the last micro-op has issued.
- Each micro-op reaches the forwarding/hazard logic as an ordinary `lw`/`sw` with a destination or source register, a base register and a word offset.

---
 rtl/lmsm_sequencer_pkg.sv | 22 ++
 rtl/lmsm_sequencer_if.sv | 34 +++
 rtl/lmsm_sequencer_lsb_pick.sv | 27 ++
 rtl/lmsm_sequencer.sv | 164 ++++++++++++++++
 tb/tb_lmsm_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/lmsm_sequencer_pkg.sv
// Shared opcodes, state encoding and sizing for the lm/sm micro-op sequencer.
// Imported by the interface, the lowest-set-bit picker and the sequencer top.
package lmsm_sequencer_pkg;

    localparam int NREG = 8;
    localparam int OFFW = 3;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

endpackage

// File: rtl/lmsm_sequencer_if.sv
// ID-stage inputs and micro-op outputs of the lm/sm sequencer.
// slave: sequencer side (DUT); master: pipeline side driving the ID fields.
interface lmsm_sequencer_if;
    import lmsm_sequencer_pkg::*;

    logic            validID;
    logic [3:0]      opcodeID;
    logic [2:0]      raID;
    logic [NREG-1:0] immID;
    logic            hold;
    logic            flush;
    logic            stallID;
    logic            busy;
    logic            uop_valid;
    logic            uop_load;
    logic [2:0]      uop_reg;
    logic [2:0]      uop_base;
    logic [OFFW-1:0] uop_off;
    logic            uop_last;
    logic [15:0]     stall_cycles;

    modport slave (
        input  validID, opcodeID, raID, immID, hold, flush,
        output stallID, busy, uop_valid, uop_load, uop_reg,
        output uop_base, uop_off, uop_last, stall_cycles
    );

    modport master (
        output validID, opcodeID, raID, immID, hold, flush,
        input  stallID, busy, uop_valid, uop_load, uop_reg,
        input  uop_base, uop_off, uop_last, stall_cycles
    );

endinterface

// File: rtl/lmsm_sequencer_lsb_pick.sv
// Combinational lowest-set-bit finder over an NREG-bit register mask.
// Ports: mask_i in; idx_o index, onehot_o isolated bit, more_o popcount>=2.
module lmsm_sequencer_lsb_pick
    import lmsm_sequencer_pkg::*;
(
    input  logic [NREG-1:0] mask_i,
    output logic [OFFW-1:0] idx_o,
    output logic [NREG-1:0] onehot_o,
    output logic            more_o
);

    // Scan high to low so the lowest set bit is the final writer.
    always_comb begin
        idx_o = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = OFFW'(i);
            end
        end
    end

    assign onehot_o = mask_i & (~mask_i + NREG'(1));

    // Clearing the lowest bit leaves something only if two or more were set.
    assign more_o = |(mask_i & (mask_i - NREG'(1)));

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands lm/sm in ID into one lw/sw-style micro-op per cycle, lowest reg first.
// Ports: clk, reset (async high), bus (slave). Macro LMSM_PERF_CNT_EN adds stall_cycles.
module lmsm_sequencer
    import lmsm_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    lmsm_sequencer_if.slave bus
);

    state_t          state_q, state_d;
    logic [NREG-1:0] mask_q, mask_d;
    logic [OFFW-1:0] cnt_q, cnt_d;
    logic [2:0]      base_q, base_d;
    logic            load_q, load_d;

    logic            uv_q, uv_d;
    logic            ul_q, ul_d;
    logic [2:0]      ur_q, ur_d;
    logic [2:0]      ub_q, ub_d;
    logic [OFFW-1:0] uo_q, uo_d;
    logic            ulast_q, ulast_d;

    logic [NREG-1:0] sel;
    logic [OFFW-1:0] idx;
    logic [NREG-1:0] onehot;
    logic            more;
    logic            is_lmsm;
    logic            start;

    assign is_lmsm = (bus.opcodeID == OP_LM) | (bus.opcodeID == OP_SM);
    assign start   = bus.validID & is_lmsm & ~bus.hold & ~bus.flush
                   & (state_q == IDLE);
    assign sel     = (state_q == SEQ) ? mask_q : bus.immID;

    lmsm_sequencer_lsb_pick u_pick (
        .mask_i   (sel),
        .onehot_o (onehot),
        .idx_o    (idx),
        .more_o   (more)
    );

    // Hold does not mask the stall: ID must stay put while frozen too.
    always_comb begin
        bus.stallID = 1'b0;
        if (!reset && !bus.flush) begin
            if (state_q == SEQ) begin
                bus.stallID = more;
            end else begin
                bus.stallID = bus.validID & is_lmsm & more;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        load_d  = load_q;
        uv_d    = uv_q;
        ul_d    = ul_q;
        ur_d    = ur_q;
        ub_d    = ub_q;
        uo_d    = uo_q;
        ulast_d = ulast_q;
        if (bus.flush) begin
            state_d = IDLE;
            mask_d  = '0;
            cnt_d   = '0;
            uv_d    = 1'b0;
        end else if (!bus.hold) begin
            unique case (state_q)
                IDLE: begin
                    uv_d = 1'b0;
                    if (start && (bus.immID != '0)) begin
                        uv_d    = 1'b1;
                        ul_d    = (bus.opcodeID == OP_LM);
                        ur_d    = idx;
                        ub_d    = bus.raID;
                        uo_d    = '0;
                        ulast_d = ~more;
                        if (more) begin
                            state_d = SEQ;
                            mask_d  = bus.immID & ~onehot;
                            cnt_d   = OFFW'(1);
                            base_d  = bus.raID;
                            load_d  = (bus.opcodeID == OP_LM);
                        end
                    end
                end
                SEQ: begin
                    uv_d    = 1'b1;
                    ul_d    = load_q;
                    ur_d    = idx;
                    ub_d    = base_q;
                    uo_d    = cnt_q;
                    ulast_d = ~more;
                    mask_d  = mask_q & ~onehot;
                    cnt_d   = cnt_q + OFFW'(1);
                    if (!more) begin
                        state_d = IDLE;
                        mask_d  = '0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            load_q  <= 1'b0;
            uv_q    <= 1'b0;
            ul_q    <= 1'b0;
            ur_q    <= '0;
            ub_q    <= '0;
            uo_q    <= '0;
            ulast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            load_q  <= load_d;
            uv_q    <= uv_d;
            ul_q    <= ul_d;
            ur_q    <= ur_d;
            ub_q    <= ub_d;
            uo_q    <= uo_d;
            ulast_q <= ulast_d;
        end
    end

    assign bus.busy      = (state_q == SEQ);
    assign bus.uop_valid = uv_q;
    assign bus.uop_load  = ul_q;
    assign bus.uop_reg   = ur_q;
    assign bus.uop_base  = ub_q;
    assign bus.uop_off   = uo_q;
    assign bus.uop_last  = ulast_q;

`ifdef LMSM_PERF_CNT_EN
    logic [15:0] scnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scnt_q <= '0;
        end else if (bus.stallID && (scnt_q != 16'hFFFF)) begin
            scnt_q <= scnt_q + 16'd1;
        end
    end

    assign bus.stall_cycles = scnt_q;
`else
    assign bus.stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: lm/sm expansion, hold, flush, reset.
// Expected values are hand-derived per step.
module tb_lmsm_sequencer;
    import lmsm_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    lmsm_sequencer_if bus ();

    lmsm_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef LMSM_PERF_CNT_EN
    localparam logic [15:0] EXP_PERF = 16'd7;
`else
    localparam logic [15:0] EXP_PERF = 16'd0;
`endif

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {valid, load, last, reg, base, off}
    function automatic logic [15:0] pk(input logic v, input logic l,
                                       input logic t, input logic [2:0] r,
                                       input logic [2:0] b,
                                       input logic [2:0] o);
        return {4'h0, v, l, t, r, b, o};
    endfunction

    function automatic logic [15:0] uop();
        return pk(bus.uop_valid, bus.uop_load, bus.uop_last,
                  bus.uop_reg, bus.uop_base, bus.uop_off);
    endfunction

    task automatic drv(input logic v, input logic [3:0] op,
                       input logic [2:0] ra, input logic [7:0] imm,
                       input logic h, input logic f);
        bus.validID  = v;
        bus.opcodeID = op;
        bus.raID     = ra;
        bus.immID    = imm;
        bus.hold     = h;
        bus.flush    = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drv(0, OP_ADD, 0, 8'h00, 0, 0);
        tick();
        tick();
        chk("rst_uop", uop(), 16'h0000);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_stall", 16'(bus.stallID), 16'd0);
        chk("rst_perf", bus.stall_cycles, 16'd0);
        reset = 1'b0;

        // lm R3, 1010_0101
        drv(1, OP_LM, 3, 8'hA5, 0, 0);
        #1;
        chk("lm_stall_t", 16'(bus.stallID), 16'd1);
        chk("lm_busy_t", 16'(bus.busy), 16'd0);
        tick();
        chk("lm_u0", uop(), pk(1, 1, 0, 0, 3, 0));
        chk("lm_stall_t1", 16'(bus.stallID), 16'd1);
        chk("lm_busy_t1", 16'(bus.busy), 16'd1);
        tick();
        chk("lm_u1", uop(), pk(1, 1, 0, 2, 3, 1));
        chk("lm_stall_t2", 16'(bus.stallID), 16'd1);
        tick();
        chk("lm_u2", uop(), pk(1, 1, 0, 5, 3, 2));
        chk("lm_stall_t3", 16'(bus.stallID), 16'd0);
        drv(0, OP_ADD, 0, 8'h00, 0, 0);
        tick();
        chk("lm_u3", uop(), pk(1, 1, 1, 7, 3, 3));
        chk("lm_busy_end", 16'(bus.busy), 16'd0);
        tick();
        chk("lm_idle", 16'(bus.uop_valid), 16'd0);

        // sm R1, single bit 4
        drv(1, OP_SM, 1, 8'h10, 0, 0);
        #1;
        chk("sm1_stall", 16'(bus.stallID), 16'd0);
        tick();
        chk("sm1_u", uop(), pk(1, 0, 1, 4, 1, 0));
        chk("sm1_busy", 16'(bus.busy), 16'd0);
        drv(0, OP_ADD, 0, 8'h00, 0, 0);
        tick();
        chk("sm1_idle", 16'(bus.uop_valid), 16'd0);

        // lm with empty mask retires as NOP
        drv(1, OP_LM, 2, 8'h00, 0, 0);
        #1;
        chk("nop_stall", 16'(bus.stallID), 16'd0);
        tick();
        chk("nop_valid", 16'(bus.uop_valid), 16'd0);
        chk("nop_busy", 16'(bus.busy), 16'd0);
        drv(1, OP_SM, 5, 8'h02, 0, 0);
        tick();
        chk("nop_next", uop(), pk(1, 0, 1, 1, 5, 0));
        drv(0, OP_ADD, 0, 8'h00, 0, 0);
        tick();

        // lm 8'hFF flushed in the 2nd SEQ cycle
        drv(1, OP_LM, 4, 8'hFF, 0, 0);
        tick();
        chk("fl_u0", uop(), pk(1, 1, 0, 0, 4, 0));
        tick();
        chk("fl_u1", uop(), pk(1, 1, 0, 1, 4, 1));
        drv(1, OP_LM, 4, 8'hFF, 0, 1);
        #1;
        chk("fl_stall", 16'(bus.stallID), 16'd0);
        tick();
        chk("fl_valid", 16'(bus.uop_valid), 16'd0);
        chk("fl_busy", 16'(bus.busy), 16'd0);
        drv(1, OP_SM, 6, 8'h01, 0, 0);
        #1;
        chk("fl_sm_stall", 16'(bus.stallID), 16'd0);
        tick();
        chk("fl_sm_u", uop(), pk(1, 0, 1, 0, 6, 0));
        drv(0, OP_ADD, 0, 8'h00, 0, 0);
        tick();

        // sm 0000_1110 with a 2-cycle hold after the first micro-op
        drv(1, OP_SM, 2, 8'h0E, 0, 0);
        tick();
        chk("hd_u0", uop(), pk(1, 0, 0, 1, 2, 0));
        drv(1, OP_SM, 2, 8'h0E, 1, 0);
        #1;
        chk("hd_stall", 16'(bus.stallID), 16'd1);
        tick();
        chk("hd_frz1", uop(), pk(1, 0, 0, 1, 2, 0));
        chk("hd_busy", 16'(bus.busy), 16'd1);
        tick();
        chk("hd_frz2", uop(), pk(1, 0, 0, 1, 2, 0));
        drv(1, OP_SM, 2, 8'h0E, 0, 0);
        tick();
        chk("hd_u1", uop(), pk(1, 0, 0, 2, 2, 1));
        chk("hd_stall_end", 16'(bus.stallID), 16'd0);
        drv(0, OP_ADD, 0, 8'h00, 0, 0);
        tick();
        chk("hd_u2", uop(), pk(1, 0, 1, 3, 2, 2));
        chk("hd_busy_end", 16'(bus.busy), 16'd0);
        tick();
        chk("hd_idle", 16'(bus.uop_valid), 16'd0);

        // async reset in the middle of lm 8'hFF
        drv(1, OP_LM, 7, 8'hFF, 0, 0);
        tick();
        tick();
        tick();
        chk("ar_pre", uop(), pk(1, 1, 0, 2, 7, 2));
        #2;
        reset = 1'b1;
        #1;
        chk("ar_uop", uop(), 16'h0000);
        chk("ar_busy", 16'(bus.busy), 16'd0);
        chk("ar_stall", 16'(bus.stallID), 16'd0);
        chk("ar_perf", bus.stall_cycles, 16'd0);
        drv(0, OP_ADD, 0, 8'h00, 0, 0);
        #1;
        reset = 1'b0;
        tick();
        chk("ar_after", 16'(bus.uop_valid), 16'd0);

        // uninterrupted lm 8'hFF: offsets 0..7, 7 stall cycles
        drv(1, OP_LM, 1, 8'hFF, 0, 0);
        tick();
        chk("ff_u0", uop(), pk(1, 1, 0, 0, 1, 0));
        drv(0, OP_ADD, 0, 8'h00, 0, 0);
        for (int i = 1; i < 7; i++) begin
            tick();
            chk("ff_mid", uop(), pk(1, 1, 0, 3'(i), 1, 3'(i)));
        end
        tick();
        chk("ff_u7", uop(), pk(1, 1, 1, 7, 1, 7));
        chk("ff_perf", bus.stall_cycles, EXP_PERF);
        tick();
        chk("ff_idle", 16'(bus.uop_valid), 16'd0);
        chk("ff_perf_hold", bus.stall_cycles, EXP_PERF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
